// File: rtl/pc_unit_pkg.sv
// Shared control constants for the PC stage: next-PC select encodings,
// PC-stage FSM states and the default reset vector.
package pc_unit_pkg;

  typedef enum logic [1:0] {
    NextIns = 2'b00,
    RelJmp  = 2'b01,
    AbsJmp  = 2'b10,
    HALT    = 2'b11
  } pcSel_e;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } pcState_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Word offset to signed byte offset.
  function automatic logic [31:0] branchOffset(input logic [15:0] imm);
    branchOffset = {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_unit_pc_next_calc.sv
// Combinational next-PC computation for the PC stage; HALT selects the
// current PC so the caller can load unconditionally.
module pc_next_calc
  import pc_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pcSel,
  input  logic [15:0] imm16,
  input  logic [25:0] jAddr,
  output logic [31:0] nextPc
);

  logic [31:0] seqPc;

  assign seqPc = pc + 32'd4;

  always_comb begin
    nextPc = seqPc;
    unique case (pcSel_e'(pcSel))
      NextIns: nextPc = seqPc;
      RelJmp:  nextPc = seqPc + branchOffset(imm16);
      AbsJmp:  nextPc = {seqPc[31:28], jAddr, 2'b00};
      HALT:    nextPc = pc;
      default: nextPc = seqPc;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: PC register, RUN/HALTED state machine and an
// optional retired-instruction counter enabled by `define PC_INSTRET_EN.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  PCSel,
  input  logic [15:0] Imm16,
  input  logic [25:0] JAddr,
  input  logic        IMemReady,
  input  logic        Resume,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Halted,
  output logic [31:0] InstRet,
  output logic        DbgState
);

  // Handshake: IMemReady is the valid for the instruction addressed by PC.
  // The stage has no backpressure; an instruction retires on every edge
  // where the state is RUN and IMemReady is high, otherwise nothing moves.

  pcState_e    state;
  pcState_e    stateNext;
  logic [31:0] pcNext;
  logic [31:0] pcCalc;
  logic        retire;

  pc_next_calc uNextCalc (
    .pc     (PC),
    .pcSel  (PCSel),
    .imm16  (Imm16),
    .jAddr  (JAddr),
    .nextPc (pcCalc)
  );

  assign PCPlus4  = PC + 32'd4;
  assign Halted   = (state == HALTED);
  assign DbgState = state;

  always_comb begin
    stateNext = state;
    pcNext    = PC;
    retire    = 1'b0;
    unique case (state)
      RUN: begin
        if (IMemReady) begin
          retire = 1'b1;
          pcNext = pcCalc;
          if (pcSel_e'(PCSel) == HALT) begin
            stateNext = HALTED;
          end
        end
      end
      HALTED: begin
        if (Resume) begin
          pcNext    = PCPlus4;
          stateNext = RUN;
        end
      end
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      PC    <= RESET_PC;
    end else begin
      state <= stateNext;
      PC    <= pcNext;
    end
  end

`ifdef PC_INSTRET_EN
  logic [31:0] instRetCnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      instRetCnt <= 32'h0;
    end else if (retire) begin
      instRetCnt <= instRetCnt + 32'd1;
    end
  end

  assign InstRet = instRetCnt;
`else
  logic unusedRetire;
  assign unusedRetire = retire;
  assign InstRet      = 32'h0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit: sequential, relative/absolute jumps,
// wrap-around, stall, halt/resume and reset-while-halted.
module tb_pc_unit;

  localparam logic [1:0] SEL_NEXT = 2'b00;
  localparam logic [1:0] SEL_REL  = 2'b01;
  localparam logic [1:0] SEL_ABS  = 2'b10;
  localparam logic [1:0] SEL_HALT = 2'b11;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  PCSel;
  logic [15:0] Imm16;
  logic [25:0] JAddr;
  logic        IMemReady;
  logic        Resume;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        Halted;
  logic [31:0] InstRet;
  logic        DbgState;

  int numChecks = 0;
  int numFails  = 0;
  logic [31:0] expCnt = 32'h0;

  pc_unit dut (
    .CLK       (CLK),
    .RST       (RST),
    .PCSel     (PCSel),
    .Imm16     (Imm16),
    .JAddr     (JAddr),
    .IMemReady (IMemReady),
    .Resume    (Resume),
    .PC        (PC),
    .PCPlus4   (PCPlus4),
    .Halted    (Halted),
    .InstRet   (InstRet),
    .DbgState  (DbgState)
  );

  always #5 CLK = ~CLK;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample #1 after the rising edge.
  task automatic step(input logic [1:0] sel, input logic [15:0] imm, input logic [25:0] ja,
                      input logic rdy, input logic res);
    PCSel     = sel;
    Imm16     = imm;
    JAddr     = ja;
    IMemReady = rdy;
    Resume    = res;
    @(posedge CLK);
    #1;
  endtask

  task automatic retireOne(input logic [1:0] sel, input logic [15:0] imm, input logic [25:0] ja);
    step(sel, imm, ja, 1'b1, 1'b0);
    expCnt = expCnt + 32'd1;
  endtask

  task automatic checkPc(input string tag, input logic [31:0] expPc, input logic expHalt);
    logic [31:0] expRet;
`ifdef PC_INSTRET_EN
    expRet = expCnt;
`else
    expRet = 32'h0;
`endif
    checkVal({tag, ".pc"}, PC, expPc);
    checkVal({tag, ".pcplus4"}, PCPlus4, expPc + 32'd4);
    checkVal({tag, ".halted"}, {31'h0, Halted}, {31'h0, expHalt});
    checkVal({tag, ".state"}, {31'h0, DbgState}, {31'h0, expHalt});
    checkVal({tag, ".instret"}, InstRet, expRet);
  endtask

  initial begin
    RST = 1'b1;
    step(SEL_NEXT, 16'h0, 26'h0, 1'b0, 1'b0);
    step(SEL_NEXT, 16'h0, 26'h0, 1'b0, 1'b0);
    RST = 1'b0;
    checkPc("reset", 32'h0, 1'b0);

    retireOne(SEL_NEXT, 16'h0, 26'h0); checkPc("seq1", 32'h4, 1'b0);
    retireOne(SEL_NEXT, 16'h0, 26'h0); checkPc("seq2", 32'h8, 1'b0);
    retireOne(SEL_NEXT, 16'h0, 26'h0); checkPc("seq3", 32'hC, 1'b0);

    retireOne(SEL_ABS, 16'h0, 26'h0000040);  checkPc("abs_to_100", 32'h100, 1'b0);
    retireOne(SEL_REL, 16'hFFFE, 26'h0);     checkPc("rel_back", 32'hFC, 1'b0);
    retireOne(SEL_ABS, 16'h0, 26'h0000040);  checkPc("abs_to_100b", 32'h100, 1'b0);
    retireOne(SEL_REL, 16'h0003, 26'h0);     checkPc("rel_fwd", 32'h110, 1'b0);

    // Stall with a pending relative jump: nothing moves.
    step(SEL_REL, 16'h0010, 26'h0, 1'b0, 1'b0); checkPc("stall1", 32'h110, 1'b0);
    step(SEL_REL, 16'h0010, 26'h0, 1'b0, 1'b0); checkPc("stall2", 32'h110, 1'b0);
    retireOne(SEL_REL, 16'h0010, 26'h0);        checkPc("stall_rel", 32'h154, 1'b0);

    retireOne(SEL_ABS, 16'h0, 26'h0000000);  checkPc("abs_zero", 32'h0, 1'b0);
    retireOne(SEL_REL, 16'hFFF0, 26'h0);     checkPc("rel_wrap_neg", 32'hFFFF_FFC4, 1'b0);
    retireOne(SEL_ABS, 16'h0, 26'h0000004);  checkPc("abs_hi_nib", 32'hF000_0010, 1'b0);
    retireOne(SEL_ABS, 16'h0, 26'h0000040);  checkPc("abs_spec", 32'hF000_0100, 1'b0);
    retireOne(SEL_ABS, 16'h0, 26'h3FFFFFF);  checkPc("abs_top", 32'hFFFF_FFFC, 1'b0);
    retireOne(SEL_NEXT, 16'h0, 26'h0);       checkPc("seq_wrap", 32'h0, 1'b0);

    retireOne(SEL_ABS, 16'h0, 26'h0000008);  checkPc("abs_to_20", 32'h20, 1'b0);
    retireOne(SEL_HALT, 16'h0, 26'h0);       checkPc("halt_enter", 32'h20, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(2'(i % 3), 16'h0003, 26'h0000040, 1'(i % 2), 1'b0);
      checkPc("halt_hold", 32'h20, 1'b1);
    end
    step(SEL_REL, 16'h0003, 26'h0, 1'b0, 1'b1); checkPc("resume", 32'h24, 1'b0);

    // Resume in RUN is ignored; only the normal retire happens.
    PCSel = SEL_NEXT; Imm16 = 16'h0; JAddr = 26'h0; IMemReady = 1'b1; Resume = 1'b1;
    @(posedge CLK); #1;
    expCnt = expCnt + 32'd1;
    checkPc("resume_in_run", 32'h28, 1'b0);

    retireOne(SEL_HALT, 16'h0, 26'h0); checkPc("halt2", 32'h28, 1'b1);
    RST = 1'b1;
    step(SEL_NEXT, 16'h0, 26'h0, 1'b1, 1'b1);
    RST = 1'b0;
    expCnt = 32'h0;
    checkPc("rst_in_halt", 32'h0, 1'b0);

    retireOne(SEL_NEXT, 16'h0, 26'h0); checkPc("post_rst", 32'h4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
